i2c_wb_sequencer: RTL and testbench

I2C_WB_SEQUENCER -- requirements
Module: i2c_wb_sequencer

---
 rtl/i2c_wb_sequencer_if.sv | 13 +
 rtl/i2c_wb_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_wb_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_wb_sequencer_if.sv
// Wishbone link between the sequencer (master) and the I2C controller register file (slave).
interface i2c_wb_sequencer_if;
  logic       cyc_o;
  logic       stb_o;
  logic       we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;

  modport master (output cyc_o, stb_o, we_o, adr_o, dat_o, input dat_i, ack_i);
  modport slave  (input cyc_o, stb_o, we_o, adr_o, dat_o, output dat_i, ack_i);
endinterface

// File: rtl/i2c_wb_sequencer.sv
// Runs complete I2C read/write transactions by sequencing CSR/DPR/CMDR accesses over Wishbone.
// Define I2C_WB_SEQ_IRQ_EN to wait for irq_i before each CMDR status read instead of polling.
module i2c_wb_sequencer #(
  parameter int unsigned BUS_ID = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_rd,
  input  logic [6:0]         req_addr,
  input  logic [3:0]         req_len,
  input  logic [7:0]         wr_data,
  output logic               wr_ready,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic               done,
  output logic [1:0]         status,
  input  logic               irq_i,
  i2c_wb_sequencer_if.master wb
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_DPR_BUS, S_CMD_BUS, S_CMD_START, S_DPR_ADDR, S_CMD_ADDR, S_DPR_WR,
    S_CMD_WR, S_CMD_RD, S_RD_DPR, S_NEXT, S_CMD_STOP, S_POLL, S_IRQ, S_DONE
  } state_t;

  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;

`ifdef I2C_WB_SEQ_IRQ_EN
  localparam logic [7:0] CSR_INIT = 8'hC0;
  localparam state_t     S_WAIT   = S_IRQ;
`else
  localparam logic [7:0] CSR_INIT = 8'h80;
  localparam state_t     S_WAIT   = S_POLL;
`endif

  state_t     state_q, state_d, ret_q, ret_d, nxt, ret_nxt;
  logic       rd_q, rd_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cyc_q, cyc_d, we_q, we_d;
  logic [1:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d, done_q, done_d;
  logic [1:0] status_q, status_d;
  logic       acc, acc_we;
  logic [1:0] acc_adr;
  logic [7:0] acc_dat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_INIT;
      ret_q      <= S_IDLE;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      status_q   <= status_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    status_d   = status_q;
    acc        = 1'b1;
    acc_we     = 1'b1;
    acc_adr    = ADR_CMDR;
    acc_dat    = '0;
    nxt        = state_q;
    ret_nxt    = ret_q;

    // Access states describe one bus cycle; nxt/ret_nxt take effect on its ack.
    case (state_q)
      S_INIT:      begin acc_adr = ADR_CSR; acc_dat = CSR_INIT; nxt = S_IDLE; end
      S_IDLE: begin
        acc = 1'b0;
        if (req_valid) begin
          rd_d     = req_rd;
          addr_d   = req_addr;
          cnt_d    = req_len;
          status_d = 2'b00;
          state_d  = S_DPR_BUS;
        end
      end
      S_DPR_BUS:   begin acc_adr = ADR_DPR; acc_dat = 8'(BUS_ID); nxt = S_CMD_BUS; end
      S_CMD_BUS:   begin acc_dat = 8'h06; nxt = S_WAIT; ret_nxt = S_CMD_START; end
      S_CMD_START: begin acc_dat = 8'h04; nxt = S_WAIT; ret_nxt = S_DPR_ADDR; end
      S_DPR_ADDR:  begin acc_adr = ADR_DPR; acc_dat = {addr_q, rd_q}; nxt = S_CMD_ADDR; end
      S_CMD_ADDR: begin
        acc_dat = 8'h01;
        nxt     = S_WAIT;
        ret_nxt = rd_q ? S_CMD_RD : S_DPR_WR;
      end
      S_DPR_WR:    begin acc_adr = ADR_DPR; acc_dat = wr_data; nxt = S_CMD_WR; end
      S_CMD_WR:    begin acc_dat = 8'h01; nxt = S_WAIT; ret_nxt = S_NEXT; end
      S_CMD_RD: begin
        acc_dat = (cnt_q == 4'd0) ? 8'h03 : 8'h02;
        nxt     = S_WAIT;
        ret_nxt = S_RD_DPR;
      end
      S_RD_DPR:    begin acc_we = 1'b0; acc_adr = ADR_DPR; nxt = S_NEXT; end
      S_NEXT: begin
        acc = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = S_CMD_STOP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = rd_q ? S_CMD_RD : S_DPR_WR;
        end
      end
      S_CMD_STOP:  begin acc_dat = 8'h05; nxt = S_WAIT; ret_nxt = S_DONE; end
      S_POLL:      begin acc_we = 1'b0; end
      S_IRQ: begin
        acc = 1'b0;
        if (irq_i) state_d = S_POLL;
      end
      S_DONE:      begin acc = 1'b0; done_d = 1'b1; state_d = S_IDLE; end
      default:     begin acc = 1'b0; state_d = S_INIT; end
    endcase

    if (acc) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        we_d  = acc_we;
        adr_d = acc_adr;
        dat_d = acc_dat;
      end else if (wb.ack_i) begin
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        adr_d   = '0;
        dat_d   = '0;
        state_d = nxt;
        ret_d   = ret_nxt;
        if (state_q == S_RD_DPR) begin
          rd_data_d  = wb.dat_i;
          rd_valid_d = 1'b1;
        end
        // Status priority ERR > AL > NAK > DON; AL/ERR end the transaction without Stop.
        if (state_q == S_POLL) begin
          if (wb.dat_i[4]) begin
            status_d = 2'b11;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else if (wb.dat_i[5]) begin
            status_d = 2'b10;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else if (wb.dat_i[6]) begin
            status_d = 2'b01;
            state_d  = (ret_q == S_DONE) ? S_DONE : S_CMD_STOP;
          end else if (wb.dat_i[7]) begin
            state_d = ret_q;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_DPR_WR) && !cyc_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign status    = status_q;
  assign wb.cyc_o  = cyc_q;
  assign wb.stb_o  = cyc_q;
  assign wb.we_o   = we_q;
  assign wb.adr_o  = adr_q;
  assign wb.dat_o  = dat_q;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Directed bench: scoreboarded Wishbone writes, read data and done status against a controller model.
module tb_i2c_wb_sequencer;
  localparam int unsigned   BUS      = 5;
  localparam logic [7:0]    CSR_INIT = 8'h80;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid, req_ready, req_rd;
  logic [6:0] req_addr;
  logic [3:0] req_len;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, done;
  logic [1:0] status;
  logic       irq_i = 1'b0;

  i2c_wb_sequencer_if wb_if();

  i2c_wb_sequencer #(.BUS_ID(BUS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .status(status), .irq_i(irq_i), .wb(wb_if.master)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_w[$];
  logic [7:0] exp_rd[$];
  logic [1:0] exp_st[$];
  logic [7:0] wr_src[$];
  logic [7:0] rd_src[$];
  int         ack_dly = 0;
  logic       al_start = 1'b0;
  logic       err_setbus = 1'b0;
  int         wr_cnt = 0;
  int         done_cnt = 0;

  // controller model state
  int         wcnt = 0;
  int         busy = 0;
  logic       pending = 1'b0;
  logic [7:0] resp = 8'h00;
  logic [7:0] dpr_w = 8'h00;
  logic [7:0] dpr_rd = 8'h00;
  logic [11:0] snap;
  logic       stable;
  logic       pop_next = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ew(input logic [1:0] adr, input logic [7:0] dat);
    exp_w.push_back({adr, dat});
  endtask

  task automatic prefix(input logic [7:0] addr_byte);
    ew(2'd1, 8'(BUS));
    ew(2'd2, 8'h06);
    ew(2'd2, 8'h04);
    ew(2'd1, addr_byte);
    ew(2'd2, 8'h01);
  endtask

  task automatic bus_access();
    logic [9:0] got;
    got = {wb_if.adr_o, wb_if.dat_o};
    if (wb_if.we_o) begin
      check("wb_wr_expected", 32'(exp_w.size() != 0), 32'd1);
      if (exp_w.size() != 0) check("wb_wr", 32'(got), 32'(exp_w.pop_front()));
      if (wb_if.adr_o == 2'd1) dpr_w = wb_if.dat_o;
      if (wb_if.adr_o == 2'd2) begin
        pending = 1'b1;
        busy    = 3;
        resp    = 8'h80;
        case (wb_if.dat_o)
          8'h06: if (err_setbus) resp = 8'h10;
          8'h04: if (al_start) resp = 8'h20;
          8'h01: if (dpr_w == 8'hFE) resp = 8'h40;
          8'h02, 8'h03: begin
            if (rd_src.size() != 0) dpr_rd = rd_src.pop_front();
            else dpr_rd = 8'h00;
          end
          default: ;
        endcase
      end
      wb_if.dat_i = 8'h00;
    end else begin
      if (wb_if.adr_o == 2'd2) begin
        if (pending && busy == 0) begin
          wb_if.dat_i = resp;
          pending     = 1'b0;
        end else begin
          wb_if.dat_i = 8'h00;
        end
      end else if (wb_if.adr_o == 2'd1) begin
        wb_if.dat_i = dpr_rd;
      end else begin
        wb_if.dat_i = 8'h00;
      end
    end
  endtask

  // Controller model: acks after ack_dly stall cycles, checks the request held stable.
  always @(negedge clk_i) begin
    if (busy > 0) busy--;
    wb_if.ack_i = 1'b0;
    if (wb_if.stb_o === 1'b1) begin
      if (wcnt == 0) begin
        snap   = {wb_if.cyc_o, wb_if.we_o, wb_if.adr_o, wb_if.dat_o};
        stable = 1'b1;
      end else if ({wb_if.cyc_o, wb_if.we_o, wb_if.adr_o, wb_if.dat_o} !== snap) begin
        stable = 1'b0;
      end
      if (wcnt >= ack_dly) begin
        check("wb_stable", 32'(stable), 32'd1);
        check("wb_cyc_eq_stb", 32'(wb_if.cyc_o), 32'd1);
        bus_access();
        wb_if.ack_i = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    irq_i = pending && (busy == 0);
  end

  // Write-data source: presents the queue head, advances after each captured byte.
  always @(posedge clk_i) begin
    #1;
    if (pop_next && wr_src.size() != 0) void'(wr_src.pop_front());
    pop_next = wr_ready;
    if (wr_ready) wr_cnt++;
    wr_data = (wr_src.size() != 0) ? wr_src[0] : 8'h00;
  end

  always @(negedge clk_i) begin
    if (rd_valid) begin
      check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
    end
    if (done) begin
      check("done_rd_valid_excl", 32'(rd_valid), 32'd0);
      check("done_expected", 32'(exp_st.size() != 0), 32'd1);
      if (exp_st.size() != 0) check("status", 32'(status), 32'(exp_st.pop_front()));
      check("writes_complete", 32'(exp_w.size()), 32'd0);
      done_cnt++;
    end
  end

  task automatic wait_ready(input int budget);
    int n = 0;
    @(negedge clk_i);
    while (req_ready !== 1'b1 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input logic rd, input logic [6:0] addr, input logic [3:0] len);
    wait_ready(300);
    req_rd    = rd;
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    repeat (3) @(negedge clk_i);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check("done_timeout", 32'(done_cnt != start), 32'd1);
  endtask

  initial begin
    int w0;
    int n;
    rst_i = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_addr = '0; req_len = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cyc", 32'(wb_if.cyc_o), 32'd0);
    check("rst_stb", 32'(wb_if.stb_o), 32'd0);
    check("rst_we", 32'(wb_if.we_o), 32'd0);
    check("rst_adr_dat", 32'({wb_if.adr_o, wb_if.dat_o}), 32'd0);
    check("rst_ready", 32'({req_ready, wr_ready, rd_valid, done}), 32'd0);
    check("rst_status_rd", 32'({status, rd_data}), 32'd0);
    ew(2'd0, CSR_INIT);
    rst_i = 1'b0;
    wait_ready(100);
    check("csr_init_written", 32'(exp_w.size()), 32'd0);

    // write 0x22, 3 bytes
    wr_src.delete();
    wr_src.push_back(8'h11); wr_src.push_back(8'h22); wr_src.push_back(8'h33);
    prefix(8'h44);
    ew(2'd1, 8'h11); ew(2'd2, 8'h01);
    ew(2'd1, 8'h22); ew(2'd2, 8'h01);
    ew(2'd1, 8'h33); ew(2'd2, 8'h01);
    ew(2'd2, 8'h05);
    exp_st.push_back(2'b00);
    w0 = wr_cnt;
    issue(1'b0, 7'h22, 4'd2);
    wait_done(600);
    check("wr_pulses_3", 32'(wr_cnt - w0), 32'd3);

    // read 0x22, 2 bytes
    rd_src.push_back(8'hA5); rd_src.push_back(8'h5A);
    prefix(8'h45);
    ew(2'd2, 8'h02); ew(2'd2, 8'h03); ew(2'd2, 8'h05);
    exp_rd.push_back(8'hA5); exp_rd.push_back(8'h5A);
    exp_st.push_back(2'b00);
    issue(1'b1, 7'h22, 4'd1);
    wait_done(600);
    check("rd_all_seen", 32'(exp_rd.size()), 32'd0);

    // address NAK
    wr_src.delete();
    wr_src.push_back(8'h01); wr_src.push_back(8'h02); wr_src.push_back(8'h03);
    prefix(8'hFE);
    ew(2'd2, 8'h05);
    exp_st.push_back(2'b01);
    w0 = wr_cnt;
    issue(1'b0, 7'h7F, 4'd2);
    wait_done(600);
    check("nak_no_wr_pulses", 32'(wr_cnt - w0), 32'd0);

    // arbitration lost during Start
    al_start = 1'b1;
    ew(2'd1, 8'(BUS)); ew(2'd2, 8'h06); ew(2'd2, 8'h04);
    exp_st.push_back(2'b10);
    issue(1'b0, 7'h22, 4'd0);
    wait_done(600);
    @(negedge clk_i);
    check("al_ready_after_done", 32'(req_ready), 32'd1);
    repeat (10) @(negedge clk_i);
    al_start = 1'b0;

    // controller error on Set Bus
    err_setbus = 1'b1;
    ew(2'd1, 8'(BUS)); ew(2'd2, 8'h06);
    exp_st.push_back(2'b11);
    issue(1'b0, 7'h22, 4'd0);
    wait_done(600);
    repeat (10) @(negedge clk_i);
    err_setbus = 1'b0;

    // slow acks, single-byte write then single-byte read
    ack_dly = 5;
    wr_src.delete();
    wr_src.push_back(8'h77);
    prefix(8'h20);
    ew(2'd1, 8'h77); ew(2'd2, 8'h01); ew(2'd2, 8'h05);
    exp_st.push_back(2'b00);
    w0 = wr_cnt;
    issue(1'b0, 7'h10, 4'd0);
    wait_done(3000);
    check("slow_wr_pulses_1", 32'(wr_cnt - w0), 32'd1);
    rd_src.delete();
    rd_src.push_back(8'hC3);
    prefix(8'h63);
    ew(2'd2, 8'h03); ew(2'd2, 8'h05);
    exp_rd.push_back(8'hC3);
    exp_st.push_back(2'b00);
    issue(1'b1, 7'h31, 4'd0);
    wait_done(3000);

    // reset while an access is stalled
    ack_dly = 1000;
    wr_src.delete();
    issue(1'b0, 7'h10, 4'd0);
    n = 0;
    while (wb_if.stb_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("stall_stb_high", 32'(wb_if.stb_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_mid_cyc", 32'(wb_if.cyc_o), 32'd0);
    check("rst_mid_stb", 32'(wb_if.stb_o), 32'd0);
    exp_w.delete();
    ew(2'd0, CSR_INIT);
    ack_dly = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_ready(100);
    check("restart_csr_written", 32'(exp_w.size()), 32'd0);
    check("no_stray_done", 32'(exp_st.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
